// File: rtl/softmax_pkg.sv
// Shared types, width helpers and the exp ROM generator for the streaming softmax.
package softmax_pkg;

    typedef enum logic [1:0] {LOAD, EXP, RECIP, NORM} state_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int sum_w(input int exp_w, input int max_len);
        return exp_w + $clog2(max_len);
    endfunction

    function automatic int recip_w(input int out_w);
        return out_w + 1;
    endfunction

    // round((2^exp_w-1) * e^(-d/2^in_frac)), evaluated in Q30 integer arithmetic
    function automatic int exp_rom_entry(input int d, input int exp_w, input int in_frac);
        longint one, base, term, acc;
        one  = longint'(1) << 30;
        base = one;
        term = one;
        for (int k = 1; k < 16; k++) begin
            term = (term >>> in_frac) / longint'(k);
            base = (k % 2 == 1) ? base - term : base + term;
        end
        acc = one;
        for (int i = 0; i < d; i++) begin
            acc = (acc * base) >>> 30;
        end
        return int'((longint'((1 << exp_w) - 1) * acc + (one >>> 1)) >>> 30);
    endfunction

endpackage

// File: rtl/softmax_exp_rom.sv
// Registered exp lookup table, contents fixed at elaboration; one cycle read latency.
module softmax_exp_rom
    import softmax_pkg::*;
#(
    parameter int LUT_AW  = 6,
    parameter int EXP_W   = 8,
    parameter int IN_FRAC = 4
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [EXP_W-1:0]  data
);

    logic [EXP_W-1:0] rom_tbl [2**LUT_AW];

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
        localparam logic [EXP_W-1:0] ENTRY = EXP_W'(exp_rom_entry(g, EXP_W, IN_FRAC));
        assign rom_tbl[g] = ENTRY;
    end

    always_ff @(posedge clk) begin
        data <= rom_tbl[addr];
    end

endmodule

// File: rtl/softmax_stream.sv
// Streaming fixed-point softmax: buffer a score vector, exp via ROM, reciprocal of the
// sum via restoring division, then stream normalised probabilities with backpressure.
module softmax_stream
    import softmax_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int IN_W    = 8,
    parameter int IN_FRAC = 4,
    parameter int LUT_AW  = 6,
    parameter int EXP_W   = 8,
    parameter int OUT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_W-1:0]                in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_W-1:0]               out_data,
    output logic                           out_last,
    output logic                           busy
);

    localparam int LEN_W   = len_w(MAX_LEN);
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int SUM_W   = sum_w(EXP_W, MAX_LEN);
    localparam int RECIP_W = recip_w(OUT_W);
    localparam int PROD_W  = EXP_W + RECIP_W;
    localparam int STEP_W  = $clog2(RECIP_W);
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RECIP_W - 1);
    localparam logic [IN_W:0]     D_MAX     = (IN_W+1)'(2**LUT_AW - 1);
    // Dividend 2^(EXP_W+OUT_W): the bits above the quotient field preload the remainder.
    localparam logic [SUM_W-1:0]  REM_INIT  = SUM_W'(2**(EXP_W-1));

    function automatic logic [LUT_AW-1:0] sat_dist(input logic [IN_W:0] d);
        return (d > D_MAX) ? '1 : d[LUT_AW-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] clamp_prob(input logic [PROD_W-1:0] p);
        logic [RECIP_W-1:0] q;
        q = p[PROD_W-1:EXP_W];
        return q[OUT_W] ? '1 : q[OUT_W-1:0];
    endfunction

    state_t                  state;
    logic [LEN_W-1:0]        len, cnt, eff_len, cur_len, nxt_cnt;
    logic [STEP_W-1:0]       step;
    logic signed [IN_W-1:0]  row_max;
    logic signed [IN_W-1:0]  score_buf [MAX_LEN];
    logic [EXP_W-1:0]        exp_buf [MAX_LEN];
    logic [SUM_W-1:0]        sum, rem, rem_next;
    logic [SUM_W:0]          rem_sh;
    logic                    rem_ge;
    logic [RECIP_W-1:0]      recip, q_next;
    logic signed [IN_W:0]    dist_p0;
    logic [LUT_AW-1:0]       addr_p0;
    logic [EXP_W-1:0]        exp_p1;
    logic                    vld_p1;
    logic [IDX_W-1:0]        idx_p1;
    logic [EXP_W-1:0]        mul_e;
    logic [RECIP_W-1:0]      mul_r;
    logic [PROD_W-1:0]       prod;

    assign in_ready = (state == LOAD);
    assign busy     = !(state == LOAD && cnt == '0);

    always_comb begin
        eff_len  = (cfg_len == '0 || cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
        cur_len  = (cnt == '0) ? eff_len : len;
        nxt_cnt  = cnt + LEN_W'(1);
        dist_p0  = (IN_W+1)'(row_max) - (IN_W+1)'(score_buf[cnt[IDX_W-1:0]]);
        addr_p0  = sat_dist(dist_p0);
        rem_sh   = {rem, 1'b0};
        rem_ge   = rem_sh >= {1'b0, sum};
        rem_next = rem_ge ? SUM_W'(rem_sh - {1'b0, sum}) : rem_sh[SUM_W-1:0];
        q_next   = {recip[RECIP_W-2:0], rem_ge};
        // The first output beat is formed on the last divide step, before recip is registered.
        mul_e    = (state == RECIP) ? exp_buf[0] : exp_buf[nxt_cnt[IDX_W-1:0]];
        mul_r    = (state == RECIP) ? q_next : recip;
        prod     = PROD_W'(mul_e) * PROD_W'(mul_r);
    end

    // p0 -> p1: distance address into the ROM, exp value returns one cycle later
    softmax_exp_rom #(
        .LUT_AW (LUT_AW),
        .EXP_W  (EXP_W),
        .IN_FRAC(IN_FRAC)
    ) u_rom (
        .clk (clk),
        .addr(addr_p0),
        .data(exp_p1)
    );

    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) score_buf[cnt[IDX_W-1:0]] <= in_data;
        if (state == EXP && vld_p1)    exp_buf[idx_p1] <= exp_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            len       <= '0;
            cnt       <= '0;
            step      <= '0;
            row_max   <= '0;
            sum       <= '0;
            rem       <= '0;
            recip     <= '0;
            vld_p1    <= 1'b0;
            idx_p1    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            vld_p1 <= (state == EXP) && (cnt != len);
            idx_p1 <= cnt[IDX_W-1:0];
            case (state)
                LOAD: if (in_valid) begin
                    if (cnt == '0) begin
                        len     <= eff_len;
                        row_max <= $signed(in_data);
                    end else if ($signed(in_data) > row_max) begin
                        row_max <= $signed(in_data);
                    end
                    if (cnt == cur_len - LEN_W'(1)) begin
                        state <= EXP;
                        cnt   <= '0;
                        sum   <= '0;
                    end else begin
                        cnt <= nxt_cnt;
                    end
                end
                EXP: begin
                    if (vld_p1) sum <= sum + SUM_W'(exp_p1);
                    if (cnt == len) begin
                        state <= RECIP;
                        cnt   <= '0;
                        step  <= '0;
                        rem   <= REM_INIT;
                        recip <= '0;
                    end else begin
                        cnt <= nxt_cnt;
                    end
                end
                RECIP: begin
                    rem   <= rem_next;
                    recip <= q_next;
                    if (step == STEP_LAST) begin
                        state     <= NORM;
                        out_valid <= 1'b1;
                        out_data  <= clamp_prob(prod);
                        out_last  <= (len == LEN_W'(1));
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                NORM: if (out_ready) begin
                    if (cnt == len - LEN_W'(1)) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                    end else begin
                        cnt      <= nxt_cnt;
                        out_data <= clamp_prob(prod);
                        out_last <= (nxt_cnt == len - LEN_W'(1));
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: doc/softmax_stream.md
Name: softmax_stream

Overview:
Streaming fixed-point softmax engine, the successor to the single-shot softmax block. It accepts one score vector per transaction over a valid/ready input, with a runtime length of up to MAX_LEN elements, and subtracts the row maximum for numerical stability. It then evaluates exp through a registered ROM, accumulates the sum, computes the reciprocal with a sequential divider, and streams normalised probabilities out with backpressure and a last flag. It sits between the attention score matmul and the score-times-V stage.

Parameters:
MAX_LEN, 16, maximum vector length (buffer depth); must be ≥2.
IN_W, 8, signed input score width.
IN_FRAC, 4, fractional bits of input score.
LUT_AW, 6, exp ROM address width; d = max−x saturates at 2^LUT_AW−1.
EXP_W, 8, unsigned exp ROM data width.
OUT_W, 8, output probability width, Q0.OUT_W.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_len  in  clog2(MAX_LEN+1)  vector length; sampled on the first accepted input beat; 0 or >MAX_LEN is treated as MAX_LEN
in_valid  in  1  score beat valid
in_ready  out  1  high only in LOAD state
in_data  in  IN_W  signed score
out_valid  out  1  probability beat valid
out_ready  in  1  downstream accept
out_data  out  OUT_W  probability
out_last  out  1  high on the final output beat of the vector
busy  out  1  high in any state other than LOAD-with-count-0

Behaviour:
- Reset values: in_ready=1 (state LOAD), out_valid=0, out_data=0, out_last=0, busy=0. All counters, max, sum, and divider registers clear. Reset mid-operation aborts the vector; no partial output is produced.
- LOAD:
  - Each in_valid&&in_ready beat writes in_data into score_buf[cnt] and updates max (signed compare; max initialises from the first beat).
  - After len beats: go to EXP, in_ready=0 from the next cycle.
- EXP:
  - For each i, d = max − score_buf[i], computed in IN_W+1 bits and unsigned; saturate to 2^LUT_AW−1.
  - The ROM has 1-cycle read latency.
  - exp_buf[i] = ROM(d); sum += exp_buf[i]. Sum width is EXP_W+clog2(MAX_LEN).
  - Takes len+1 cycles, then RECIP.
- ROM contents: entry(d) = round((2^EXP_W−1)·e^(−d/2^IN_FRAC)). entry(0)=2^EXP_W−1, so sum ≥ 2^EXP_W−1 and is never 0.
- RECIP:
  - Restoring divider computes recip = floor(2^(EXP_W+OUT_W)/sum), OUT_W+1 bits.
  - One quotient bit per cycle; takes exactly OUT_W+1 cycles, then NORM.
- NORM:
  - Beat i: out_data = min((exp_buf[i]·recip) >> EXP_W, 2^OUT_W−1).
  - out_valid is held with data stable until out_ready; the index advances only on out_valid&&out_ready.
  - out_last=1 on beat len−1.
  - After the final handshake: go to LOAD, out_valid=0, in_ready=1 next cycle.
- Latency with no stalls: from the last input beat to the first output beat is len+1+OUT_W+1+1 cycles.
- One vector is in flight at a time; there is no overlap of LOAD with NORM.
- len=1: the single output is floor((2^EXP_W−1)·recip >> EXP_W).
- out_ready held low indefinitely: the block stalls in NORM with all state preserved.
- in_valid while in_ready=0 is ignored; no data is captured.

Decomposition:
- Package softmax_pkg holds:
  - state enum {LOAD, EXP, RECIP, NORM};
  - function clog2-based width constants: LEN_W, SUM_W = EXP_W+clog2(MAX_LEN), RECIP_W = OUT_W+1;
  - the ROM init function that generates the exp table at elaboration.
- One sub-module, softmax_exp_rom: registered ROM, LUT_AW in, EXP_W out, 1-cycle latency.
- The divider stays inline in the FSM.

Test Plan:
- MAX_LEN=16, len=4, scores all 0x10 → exp=255 each, sum=1020, recip=64, outputs 63,63,63,63 with out_last on the 4th beat.
- len=4, scores {127,−128,−128,−128} → d saturates to 63, entry=5, sum=270, recip=242, outputs 241,4,4,4.
- Random out_ready toggling (50%) during the previous case → identical data sequence, out_data stable while stalled, exactly 4 handshakes.
- cfg_len=1, score −5 → single output floor(255·257>>8)=255 (clamp check), out_last=1 on that beat.
- cfg_len=0 → behaves as len=16; sixteen equal scores → recip=16, each output 15.
- rst asserted mid-RECIP → outputs return to reset values immediately, in_ready=1 after release, and the next vector processes correctly.
